// File: rtl/demux1x4_behav.sv
// Purpose : byte un-striper; deals consecutive valid bytes round-robin into 4 lanes, emits a frame.
// Latency : 1 clk from the 4th valid byte (or flush / COM trigger) to out_strobe.
// Backpr. : none; the consumer must sample out0..out3 on out_strobe.
//
// Optional feature macro: COM_ALIGN_EN (COM symbol forces lane-0 alignment).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears outputs, pointer, idle counter and slots
//   in         {data[DATA_W-1:0], valid}
//   out0..3    lane words of the last emitted frame; [0]=1 means the lane holds a real byte
//   out_strobe one-cycle pulse when out0..out3 carry a new frame
module demux1x4_behav #(
  parameter int                DATA_W    = 8,
  parameter int                FLUSH_CYC = 16,
  parameter logic [DATA_W-1:0] COM_SYM   = 8'hBC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DATA_W:0] in,
  output logic [DATA_W:0] out0,
  output logic [DATA_W:0] out1,
  output logic [DATA_W:0] out2,
  output logic [DATA_W:0] out3,
  output logic            out_strobe
);

  localparam int CNT_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;
  // Counter value on the cycle whose idle input completes the FLUSH_CYC-th idle cycle.
  localparam logic [CNT_W-1:0] FLUSH_LAST = (FLUSH_CYC > 0) ? CNT_W'(FLUSH_CYC - 1) : '0;

`ifdef COM_ALIGN_EN
  localparam bit COM_EN = 1'b1;
`else
  localparam bit COM_EN = 1'b0;
`endif

  logic [1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [DATA_W:0]   slot0_q, slot0_d;
  logic [DATA_W:0]   slot1_q, slot1_d;
  logic [DATA_W:0]   slot2_q, slot2_d;
  logic [DATA_W:0]   out0_q, out0_d;
  logic [DATA_W:0]   out1_q, out1_d;
  logic [DATA_W:0]   out2_q, out2_d;
  logic [DATA_W:0]   out3_q, out3_d;
  logic              strobe_q, strobe_d;

  logic              in_vld;
  logic              com_hit;
  logic [DATA_W:0]   part0, part1, part2;

  assign in_vld = in[0];

  // COM only realigns when it lands mid-frame; at ptr==0 it is an ordinary byte.
  assign com_hit = COM_EN && in_vld && (in[DATA_W:1] == COM_SYM) && (ptr_q != 2'd0);

  // Partial-frame view: lanes below ptr are filled, the rest read as 0
  // (slot registers may still hold bytes from an earlier frame).
  assign part0 = (ptr_q > 2'd0) ? slot0_q : '0;
  assign part1 = (ptr_q > 2'd1) ? slot1_q : '0;
  assign part2 = (ptr_q > 2'd2) ? slot2_q : '0;

  always_comb begin
    ptr_d    = ptr_q;
    idle_d   = idle_q;
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    slot2_d  = slot2_q;
    out0_d   = out0_q;
    out1_d   = out1_q;
    out2_d   = out2_q;
    out3_d   = out3_q;
    strobe_d = 1'b0;

    if (in_vld) begin
      idle_d = '0;
      if (com_hit) begin
        out0_d   = part0;
        out1_d   = part1;
        out2_d   = part2;
        out3_d   = '0;
        strobe_d = 1'b1;
        slot0_d  = in;
        ptr_d    = 2'd1;
      end else begin
        case (ptr_q)
          2'd0: slot0_d = in;
          2'd1: slot1_d = in;
          2'd2: slot2_d = in;
          default: begin
            // 4th byte goes straight to lane 3; no slot needed.
            out0_d   = slot0_q;
            out1_d   = slot1_q;
            out2_d   = slot2_q;
            out3_d   = in;
            strobe_d = 1'b1;
          end
        endcase
        ptr_d = ptr_q + 2'd1;
      end
    end else if (ptr_q == 2'd0) begin
      idle_d = '0;
    end else if (FLUSH_CYC != 0) begin
      if (idle_q == FLUSH_LAST) begin
        out0_d   = part0;
        out1_d   = part1;
        out2_d   = part2;
        out3_d   = '0;
        strobe_d = 1'b1;
        ptr_d    = 2'd0;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + CNT_W'(1);
      end
    end
    // With flushing disabled the idle count is never consumed, so it stays at 0.
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      idle_q   <= '0;
      slot0_q  <= '0;
      slot1_q  <= '0;
      slot2_q  <= '0;
      out0_q   <= '0;
      out1_q   <= '0;
      out2_q   <= '0;
      out3_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      idle_q   <= idle_d;
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      slot2_q  <= slot2_d;
      out0_q   <= out0_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      out3_q   <= out3_d;
      strobe_q <= strobe_d;
    end
  end

  assign out0       = out0_q;
  assign out1       = out1_q;
  assign out2       = out2_q;
  assign out3       = out3_q;
  assign out_strobe = strobe_q;

endmodule

// File: tb/tb_demux1x4_behav.sv
// Bench for demux1x4_behav: one instance with FLUSH_CYC=16, one with FLUSH_CYC=0,
// both fed the same serial stream.
module tb_demux1x4_behav;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] in_w;

  logic [8:0] a0, a1, a2, a3;   // FLUSH_CYC=16 instance
  logic       a_stb;
  logic [8:0] b0, b1, b2, b3;   // FLUSH_CYC=0 instance
  logic       b_stb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux1x4_behav #(.DATA_W(8), .FLUSH_CYC(16), .COM_SYM(8'hBC)) dut_f16 (
    .clk(clk), .reset(reset), .in(in_w),
    .out0(a0), .out1(a1), .out2(a2), .out3(a3), .out_strobe(a_stb)
  );

  demux1x4_behav #(.DATA_W(8), .FLUSH_CYC(0), .COM_SYM(8'hBC)) dut_f0 (
    .clk(clk), .reset(reset), .in(in_w),
    .out0(b0), .out1(b1), .out2(b2), .out3(b3), .out_strobe(b_stb)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       stb;
    logic [8:0] e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] w(input logic [7:0] d);
    return {d, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply one input word across one rising edge; return #1 after the edge.
  task automatic cyc(input logic v, input logic [7:0] d);
    in_w = {d, v};
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic stb,
                       input logic [8:0] e0, input logic [8:0] e1,
                       input logic [8:0] e2, input logic [8:0] e3);
    chk({name, "_f16"}, {27'd0, a_stb, a0, a1, a2, a3}, {27'd0, stb, e0, e1, e2, e3});
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #4 reset = 1'b0;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic stb,
                     input logic [8:0] e0, input logic [8:0] e1,
                     input logic [8:0] e2, input logic [8:0] e3);
    vec_t t;
    t.v = v; t.d = d; t.stb = stb;
    t.e0 = e0; t.e1 = e1; t.e2 = e2; t.e3 = e3;
    vecs.push_back(t);
  endtask

  initial begin
    logic [8:0] z;
    int na, nb;
    z     = 9'h000;
    reset = 1'b1;
    in_w  = 9'h000;

    // Full frame, hold, gaps with garbage data on idle cycles, back-to-back frames.
    add(1, 8'h11, 0, z, z, z, z);
    add(1, 8'h22, 0, z, z, z, z);
    add(1, 8'h33, 0, z, z, z, z);
    add(1, 8'h44, 1, w(8'h11), w(8'h22), w(8'h33), w(8'h44));
    add(0, 8'hFF, 0, w(8'h11), w(8'h22), w(8'h33), w(8'h44));
    add(1, 8'hA1, 0, w(8'h11), w(8'h22), w(8'h33), w(8'h44));
    add(0, 8'hFF, 0, w(8'h11), w(8'h22), w(8'h33), w(8'h44));
    add(1, 8'hA2, 0, w(8'h11), w(8'h22), w(8'h33), w(8'h44));
    add(0, 8'h00, 0, w(8'h11), w(8'h22), w(8'h33), w(8'h44));
    add(0, 8'h5A, 0, w(8'h11), w(8'h22), w(8'h33), w(8'h44));
    add(1, 8'hA3, 0, w(8'h11), w(8'h22), w(8'h33), w(8'h44));
    add(1, 8'hA4, 1, w(8'hA1), w(8'hA2), w(8'hA3), w(8'hA4));
    add(0, 8'hFF, 0, w(8'hA1), w(8'hA2), w(8'hA3), w(8'hA4));
    add(1, 8'h01, 0, w(8'hA1), w(8'hA2), w(8'hA3), w(8'hA4));
    add(1, 8'h02, 0, w(8'hA1), w(8'hA2), w(8'hA3), w(8'hA4));
    add(1, 8'h03, 0, w(8'hA1), w(8'hA2), w(8'hA3), w(8'hA4));
    add(1, 8'h04, 1, w(8'h01), w(8'h02), w(8'h03), w(8'h04));
    add(1, 8'h05, 0, w(8'h01), w(8'h02), w(8'h03), w(8'h04));
    add(1, 8'h06, 0, w(8'h01), w(8'h02), w(8'h03), w(8'h04));
    add(1, 8'h07, 0, w(8'h01), w(8'h02), w(8'h03), w(8'h04));
    add(1, 8'h08, 1, w(8'h05), w(8'h06), w(8'h07), w(8'h08));

    // Reset state.
    #2;
    chk("reset_f16", {27'd0, a_stb, a0, a1, a2, a3}, 64'd0);
    chk("reset_f0",  {27'd0, b_stb, b0, b1, b2, b3}, 64'd0);
    #4 reset = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d_f16", i), {27'd0, a_stb, a0, a1, a2, a3},
          {27'd0, vecs[i].stb, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3});
      chk($sformatf("vec%0d_f0", i), {27'd0, b_stb, b0, b1, b2, b3},
          {27'd0, vecs[i].stb, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3});
    end

    // Asynchronous reset mid-cycle clears held outputs at once.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_f16", {27'd0, a_stb, a0, a1, a2, a3}, 64'd0);
    chk("async_rst_f0",  {27'd0, b_stb, b0, b1, b2, b3}, 64'd0);
    #3 reset = 1'b0;

    // 3 bytes then 40 idle: FLUSH_CYC=0 never strobes; FLUSH_CYC=16 flushes once,
    // on the 16th idle cycle, then stays quiet with ptr==0.
    cyc(1, 8'hC1);
    cyc(1, 8'hC2);
    cyc(1, 8'hC3);
    na = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 8'h00);
      if (a_stb) na++;
      if (b_stb) nb++;
      if (i == 14) chk_a("preflush15", 0, z, z, z, z);
      if (i == 15) chk_a("flush3", 1, w(8'hC1), w(8'hC2), w(8'hC3), z);
    end
    chk("noflush_cnt_f0", 64'(nb), 64'd0);
    chk("flush_cnt_f16", 64'(na), 64'd1);
    chk("noflush_out_f0", {27'd0, b_stb, b0, b1, b2, b3}, 64'd0);

    // Valid byte on the cycle the count would reach FLUSH_CYC wins.
    pulse_reset();
    cyc(1, 8'h55);
    cyc(1, 8'h66);
    na = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(0, 8'h00);
      if (a_stb) na++;
    end
    cyc(1, 8'h77);
    if (a_stb) na++;
    chk("vld_wins_nostb", 64'(na), 64'd0);
    cyc(1, 8'h88);
    chk_a("vld_wins_frame", 1, w(8'h55), w(8'h66), w(8'h77), w(8'h88));

    // Flush of a 2-byte partial frame, then the next frame starts in lane 0.
    cyc(1, 8'h55);
    cyc(1, 8'h66);
    na = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00);
      if (i < 15 && a_stb) na++;
    end
    chk_a("flush2", 1, w(8'h55), w(8'h66), z, z);
    chk("flush2_early", 64'(na), 64'd0);
    cyc(1, 8'h77);
    chk_a("flush2_after", 0, w(8'h55), w(8'h66), z, z);
    cyc(1, 8'h88);
    cyc(1, 8'h99);
    cyc(1, 8'hAA);
    chk_a("post_flush_frame", 1, w(8'h77), w(8'h88), w(8'h99), w(8'hAA));

    // Reset mid-frame discards the partial frame.
    pulse_reset();
    cyc(1, 8'h01);
    cyc(1, 8'h02);
    pulse_reset();
    chk_a("midrst_clear", 0, z, z, z, z);
    na = 0;
    cyc(1, 8'h03); if (a_stb) na++;
    cyc(1, 8'h04); if (a_stb) na++;
    cyc(1, 8'h05); if (a_stb) na++;
    cyc(1, 8'h06);
    chk_a("midrst_frame", 1, w(8'h03), w(8'h04), w(8'h05), w(8'h06));
    chk("midrst_early", 64'(na), 64'd0);

    // COM handling.
    cyc(1, 8'h10);
    cyc(1, 8'h20);
    cyc(1, 8'hBC);
`ifdef COM_ALIGN_EN
    chk_a("com_partial", 1, w(8'h10), w(8'h20), z, z);
    cyc(1, 8'h30);
    cyc(1, 8'h40);
    chk_a("com_hold", 0, w(8'h10), w(8'h20), z, z);
    cyc(1, 8'h50);
    chk_a("com_frame", 1, w(8'hBC), w(8'h30), w(8'h40), w(8'h50));
`else
    chk_a("com_plain_nostb", 0, w(8'h03), w(8'h04), w(8'h05), w(8'h06));
    cyc(1, 8'h30);
    chk_a("com_plain_frame", 1, w(8'h10), w(8'h20), w(8'hBC), w(8'h30));
    cyc(1, 8'h40);
    cyc(1, 8'h50);
    chk_a("com_plain_hold", 0, w(8'h10), w(8'h20), w(8'hBC), w(8'h30));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
